// File: rtl/bird_sprite_core.sv
// Bird sprite overlay: pixel-to-bitmap addressing, palette lookup and compositing, 3-cycle latency.
// Optional BIRD_MIRROR_EN enables horizontal flip via ctrl[10].
module bird_sprite_core #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3,
  parameter int SPR_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic [11:0]           si_rgb,
  output logic [11:0]           so_rgb
);

  localparam int CW = $clog2(SPR_SIZE);

  logic [10:0] x0_p, y0_p, ctrl_p;
  logic [10:0] x0_n, y0_n, ctrl_n;
  logic [10:0] x0_a, y0_a, ctrl_a;
  logic [3:0]  tick_cnt;
  logic [1:0]  anim_frame;

  // Next pending values; a write in the same cycle as frame_tick is what gets committed.
  always_comb begin
    x0_n   = x0_p;
    y0_n   = y0_p;
    ctrl_n = ctrl_p;
    if (wr_en) begin
      case (wr_addr)
        2'd0:    x0_n   = wr_data[10:0];
        2'd1:    y0_n   = wr_data[10:0];
        2'd2:    ctrl_n = wr_data[10:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_p   <= '0;
      y0_p   <= '0;
      ctrl_p <= '0;
      x0_a   <= '0;
      y0_a   <= '0;
      ctrl_a <= '0;
    end else begin
      x0_p   <= x0_n;
      y0_p   <= y0_n;
      ctrl_p <= ctrl_n;
      if (frame_tick) begin
        x0_a   <= x0_n;
        y0_a   <= y0_n;
        ctrl_a <= ctrl_n;
      end
    end
  end

  // Animation steps use the control value that was active during the frame just ended.
  logic [3:0] period_eff;
  assign period_eff = (ctrl_a[7:4] == 4'd0) ? 4'd1 : ctrl_a[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      anim_frame <= '0;
    end else if (frame_tick) begin
      if (ctrl_a[1]) begin
        if ({1'b0, tick_cnt} + 5'd1 >= {1'b0, period_eff}) begin
          tick_cnt   <= '0;
          anim_frame <= anim_frame + 2'd1;
        end else begin
          tick_cnt <= tick_cnt + 4'd1;
        end
      end else begin
        tick_cnt <= '0;
      end
    end
  end

  logic [1:0]  frame;
  logic [11:0] xe, ye, x0e, y0e, dx, dy;
  logic        hit;
  logic [CW-1:0] col, row;

  assign frame = ctrl_a[1] ? anim_frame : ctrl_a[3:2];
  assign xe    = {1'b0, x};
  assign ye    = {1'b0, y};
  assign x0e   = {1'b0, x0_a};
  assign y0e   = {1'b0, y0_a};
  assign dx    = xe - x0e;
  assign dy    = ye - y0e;
  assign hit   = ctrl_a[0] && (xe >= x0e) && (xe < x0e + 12'(SPR_SIZE))
                           && (ye >= y0e) && (ye < y0e + 12'(SPR_SIZE));
  assign row   = dy[CW-1:0];
`ifdef BIRD_MIRROR_EN
  assign col   = ctrl_a[10] ? ~dx[CW-1:0] : dx[CW-1:0];
`else
  assign col   = dx[CW-1:0];
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, ctrl_a[10:8], wr_data[31:11], dx[11:CW], dy[11:CW]};

  function automatic logic [11:0] pal(input logic [DATA_WIDTH-1:0] idx);
    case (idx)
      3'd1:    pal = 12'hF00;
      3'd2:    pal = 12'hFF0;
      3'd3:    pal = 12'hF80;
      3'd4:    pal = 12'h000;
      3'd5:    pal = 12'hFFF;
      3'd6:    pal = 12'h0F0;
      3'd7:    pal = 12'h00F;
      default: pal = 12'h000;
    endcase
  endfunction

  logic        hit1, hit2;
  logic [11:0] bg1, bg2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr <= '0;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      bg1      <= '0;
      bg2      <= '0;
      so_rgb   <= '0;
    end else begin
      ram_addr <= {frame, row, col};
      hit1     <= hit;
      bg1      <= si_rgb;
      hit2     <= hit1;
      bg2      <= bg1;
      so_rgb   <= (hit2 && ram_dout != '0) ? pal(ram_dout) : bg2;
    end
  end

endmodule
